// File: rtl/bloom_pkg.sv
// Shared types and default geometry for the Bloom-filter lookup block.
package bloom_pkg;

  localparam int HASH_CNT   = 10;
  localparam int HASH_WIDTH = 12;

  typedef logic [HASH_CNT-1:0][HASH_WIDTH-1:0] hash_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/bloom_bit_ram.sv
// Simple dual-port 2^HASH_WIDTH x 1 bit array with a registered read.
// The read returns the stored value from before a same-cycle write.
module bloom_bit_ram #(
  parameter int HASH_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [HASH_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic [HASH_WIDTH-1:0] rd_addr,
  output logic                  rd_data
);

  logic mem [2**HASH_WIDTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bloom_filter_lookup.sv
// Bloom-filter membership test over HASH_CNT bit arrays, with a learn port,
// a full-array clear sweep and a saturating count of candidate matches.
module bloom_filter_lookup
  import bloom_pkg::*;
#(
  parameter int HASH_CNT   = bloom_pkg::HASH_CNT,
  parameter int HASH_WIDTH = bloom_pkg::HASH_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] hash_i,
  input  logic                           hash_val_i,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] learn_hash_i,
  input  logic                           learn_val_i,
  output logic                           learn_ready_o,
  input  logic                           clear_i,
  output logic                           busy_o,
  output logic                           match_o,
  output logic                           match_val_o,
  output logic [CNT_WIDTH-1:0]           match_cnt_o
);

  state_t                              state, state_nxt;
  logic [HASH_WIDTH-1:0]               clr_addr, clr_addr_nxt;
  logic                                cnt_clr;
  logic                                clearing;
  logic                                wr_en;
  logic [HASH_CNT-1:0][HASH_WIDTH-1:0] lk_hash;
  logic [HASH_CNT-1:0][HASH_WIDTH-1:0] ln_hash;
  logic [HASH_CNT-1:0]                 rd_bit;
  logic [HASH_CNT-1:0]                 rd_p1;
  logic                                vld_p0, blk_p0;
  logic                                vld_p1, blk_p1;

  assign clearing      = (state == CLEAR);
  assign busy_o        = clearing;
  assign learn_ready_o = ~clearing;
  assign wr_en         = clearing | learn_val_i;
  assign lk_hash       = hash_i;
  assign ln_hash       = learn_hash_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    cnt_clr      = 1'b0;
    case (state)
      IDLE: begin
        if (clear_i) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
          cnt_clr      = 1'b1;
        end
      end
      CLEAR: begin
        // Address wraps back to 0 on the final sweep cycle, ready for next time.
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == '1) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Sweep owns the write port while clearing, so learns are dropped then.
  for (genvar k = 0; k < HASH_CNT; k++) begin : g_ram
    bloom_bit_ram #(
      .HASH_WIDTH (HASH_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (wr_en),
      .wr_addr (clearing ? clr_addr : ln_hash[k]),
      .wr_data (~clearing),
      .rd_addr (lk_hash[k]),
      .rd_data (rd_bit[k])
    );
  end

  // Stage p0: RAM read issued; strobe and clear-in-progress flag captured.
  // Stage p1: read bits registered.
  // Stage p2: AND-reduction registered onto the outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0      <= 1'b0;
      blk_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      blk_p1      <= 1'b0;
      match_val_o <= 1'b0;
      match_o     <= 1'b0;
    end else begin
      vld_p0      <= hash_val_i;
      blk_p0      <= clearing;
      vld_p1      <= vld_p0;
      blk_p1      <= blk_p0;
      match_val_o <= vld_p1;
      match_o     <= vld_p1 & ~blk_p1 & (&rd_p1);
    end
  end

  always_ff @(posedge clk_i) begin
    rd_p1 <= rd_bit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      match_cnt_o <= '0;
    end else if (cnt_clr) begin
      match_cnt_o <= '0;
    end else if (match_val_o && match_o && !(&match_cnt_o)) begin
      match_cnt_o <= match_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_bloom_filter_lookup.sv
// Directed bench for bloom_filter_lookup with a narrow match counter so that
// saturation is reachable in a short run.
module tb_bloom_filter_lookup;
  import bloom_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  hash_vec_t     hash, learn_hash;
  logic          hash_val, learn_val, clear;
  logic          learn_ready, busy, match, match_val;
  logic [CW-1:0] match_cnt;

  int errs   = 0;
  int checks = 0;

  hash_vec_t v123, v456, v789, vseq, vseq_bad;

  always #5 clk = ~clk;

  bloom_filter_lookup #(
    .HASH_CNT   (HASH_CNT),
    .HASH_WIDTH (HASH_WIDTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .hash_i        (hash),
    .hash_val_i    (hash_val),
    .learn_hash_i  (learn_hash),
    .learn_val_i   (learn_val),
    .learn_ready_o (learn_ready),
    .clear_i       (clear),
    .busy_o        (busy),
    .match_o       (match),
    .match_val_o   (match_val),
    .match_cnt_o   (match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic hash_vec_t fill(input logic [HASH_WIDTH-1:0] v);
    hash_vec_t r;
    for (int k = 0; k < HASH_CNT; k++) r[k] = v;
    return r;
  endfunction

  task automatic learn(input hash_vec_t v);
    learn_hash = v;
    learn_val  = 1'b1;
    tick();
    learn_val  = 1'b0;
  endtask

  task automatic lookup(input string tag, input hash_vec_t v, input logic exp);
    hash     = v;
    hash_val = 1'b1;
    tick();
    hash_val = 1'b0;
    tick();
    tick();
    chk({tag, "_val"}, match_val, 1);
    chk(tag, match, exp);
  endtask

  // Counts cycles until busy drops; optional lookup/clear/learn pulses at given cycles.
  task automatic sweep(input string tag, input int look_at, input int clr_at,
                       input int lrn_at, input hash_vec_t v);
    int n;
    n = 0;
    hash       = v;
    learn_hash = v;
    while (busy === 1'b1 && n < 5000) begin
      hash_val  = (n == look_at);
      clear     = (n == clr_at);
      learn_val = (n == lrn_at);
      tick();
      n++;
      if (look_at >= 0 && n == look_at + 3) begin
        chk({tag, "_probe_val"}, match_val, 1);
        chk({tag, "_probe_match"}, match, 0);
      end
      if (n == 100) chk({tag, "_ready_low"}, learn_ready, 0);
    end
    hash_val  = 1'b0;
    clear     = 1'b0;
    learn_val = 1'b0;
    chk({tag, "_len"}, n, 4096);
  endtask

  initial begin
    rst = 1'b1; hash = '0; learn_hash = '0;
    hash_val = 1'b0; learn_val = 1'b0; clear = 1'b0;
    v123 = fill(12'h123);
    v456 = fill(12'h456);
    v789 = fill(12'h789);
    for (int k = 0; k < HASH_CNT; k++) vseq[k] = HASH_WIDTH'(k + 1);
    vseq_bad    = vseq;
    vseq_bad[9] = 12'hFFF;

    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_ready", learn_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_val", match_val, 0);
    chk("rst_cnt", match_cnt, 0);
    rst = 1'b0;

    sweep("pwr", 10, -1, -1, v123);
    chk("idle_ready", learn_ready, 1);

    learn(v123);
    lookup("t2_hit", v123, 1);
    tick();
    chk("t2_cnt", match_cnt, 1);

    learn(vseq);
    lookup("t3_miss", vseq_bad, 0);
    lookup("t3_hit", vseq, 1);
    tick();
    chk("t3_cnt", match_cnt, 2);

    // Learn and lookup issued together: read sees the pre-write contents.
    hash = v456; learn_hash = v456;
    hash_val = 1'b1; learn_val = 1'b1;
    tick();
    hash_val = 1'b0; learn_val = 1'b0;
    tick();
    tick();
    chk("t4_rbw_val", match_val, 1);
    chk("t4_rbw", match, 0);
    lookup("t4_after", v456, 1);
    learn(v456);
    lookup("t4_dup", v456, 1);
    tick();
    chk("t4_cnt", match_cnt, 4);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_busy", busy, 1);
    chk("t5_cnt_zero", match_cnt, 0);
    sweep("clr", -1, 2000, 3000, v789);
    lookup("t5_old", v123, 0);
    lookup("t5_dropped", v789, 0);

    learn(v123);
    hash = v123;
    hash_val = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 8) chk("t6_climb", match_cnt, 5);
    end
    hash_val = 1'b0;
    repeat (5) tick();
    chk("t6_sat", match_cnt, 15);

    hash_val = 1'b1;
    repeat (4) tick();
    chk("t6_pre_rst_match", match, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 1);
    chk("t6_rst_ready", learn_ready, 0);
    chk("t6_rst_match", match, 0);
    chk("t6_rst_val", match_val, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    hash_val = 1'b0;
    tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("t6_mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep("restart", -1, -1, -1, v123);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bloom_filter_lookup.md
Name: bloom_filter_lookup

Overview:
- Consumes the per-window hash vector from the CRC32-based hash calculator.
- Holds HASH_CNT independent 2^HASH_WIDTH x 1-bit Bloom bit-arrays and reports a candidate match when all HASH_CNT addressed bits are set.
- Provides a learn port that loads pattern hashes, and a clear engine that zeroes all arrays.
- Output feeds the downstream exact-match / reporting stage.

Parameters:
- HASH_CNT, 10, number of hash functions and bit-arrays.
- HASH_WIDTH, 12, hash width; each array has 2^HASH_WIDTH entries.
- CNT_WIDTH, 32, width of the saturating match counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- hash_i  in  HASH_CNT*HASH_WIDTH  lookup hash vector; element k addresses array k.
- hash_val_i  in  1  lookup strobe.
- learn_hash_i  in  HASH_CNT*HASH_WIDTH  pattern hash vector to insert.
- learn_val_i  in  1  insert strobe; accepted only when learn_ready_o=1.
- learn_ready_o  out  1  high when inserts are accepted (state IDLE).
- clear_i  in  1  single-cycle request to zero all arrays.
- busy_o  out  1  clear in progress.
- match_o  out  1  all HASH_CNT bits set for the looked-up vector.
- match_val_o  out  1  qualifies match_o.
- match_cnt_o  out  CNT_WIDTH  saturating count of match_o=1 results.

Behaviour:
- Reset values:
  - FSM = CLEAR; clear address counter = 0.
  - busy_o = 1; learn_ready_o = 0.
  - match_o = 0; match_val_o = 0; match_cnt_o = 0.
  - RAM contents are not reset; the power-on sweep initialises them.
- FSM states IDLE and CLEAR:
  - CLEAR writes 0 to address cnt in every array each cycle. cnt increments from 0 to 2^HASH_WIDTH-1, then the FSM goes to IDLE. Duration is exactly 2^HASH_WIDTH cycles (4096 at default).
  - IDLE with clear_i=1 goes to CLEAR, cnt=0, and match_cnt_o is zeroed on the same edge.
  - clear_i while in CLEAR is ignored; the sweep is not restarted.
  - rst_i asserted mid-clear restarts the sweep from 0.
- Learn:
  - In IDLE, learn_val_i=1 writes 1 to array k at learn_hash_i[k] for all k, in a single cycle.
  - In CLEAR, learn_val_i is dropped; it is not queued.
- Lookup pipeline, latency 2:
  - Cycle 0: hash_val_i is sampled and the RAM read is issued.
  - Cycle 1: read data is registered.
  - Cycle 2: the AND-reduction is registered into match_o, with match_val_o = delayed hash_val_i.
  - Fully pipelined: one lookup per cycle, no backpressure.
- Lookup during CLEAR:
  - match_val_o still follows the pipeline.
  - match_o is forced 0 for any lookup whose cycle-0 sample occurred while busy_o=1.
- Read/write collision, same array and address in the same cycle: read-before-write, so the lookup returns the old bit value.
- match_cnt_o increments by 1 on each cycle with match_val_o & match_o. It saturates at all-ones; no wrap.
- Duplicate learns are idempotent.
- Lookups with hash_val_i=0 do not affect any state.

Decomposition:
- Package bloom_pkg:
  - HASH_CNT and HASH_WIDTH constants.
  - typedef hash_vec_t = logic [HASH_CNT-1:0][HASH_WIDTH-1:0].
  - enum state_t {IDLE, CLEAR}.
- Sub-module bloom_bit_ram, instantiated HASH_CNT times:
  - Simple dual-port 2^HASH_WIDTH x 1 RAM.
  - One write port, one read port; registered read with 1-cycle latency; read-before-write on collision.
- The top level holds the FSM, clear counter, write mux (clear vs learn), pipeline registers and counter.

Test Plan:
1. Release reset → busy_o=1 and learn_ready_o=0 for exactly 4096 cycles, then busy_o=0. Any lookup issued meanwhile gives match_val_o=1 with match_o=0 two cycles later.
2. Learn vector all-elements 0x123 in IDLE, then look up the same vector → match_o=1 and match_val_o=1 two cycles later; match_cnt_o=1.
3. Learn {0x001..0x00A}, then look up the same vector with element 9 changed to 0xFFF → match_o=0. Looking up the unmodified vector → match_o=1.
4. Learn and look up vector 0x456 in the same cycle → match_o=0 (read-before-write). Repeating the lookup next cycle → match_o=1.
5. After case 2, pulse clear_i → busy_o high for 4096 cycles and match_cnt_o=0. A learn_val_i pulse during the sweep is dropped. Look up 0x123 afterwards → match_o=0.
6. CNT_WIDTH=4: 20 back-to-back matching lookups → match_cnt_o climbs to 15 and holds there. Asserting rst_i mid-sequence → all outputs return to reset values and the clear sweep restarts from 0.
